// File: rtl/lsu_mem_master.sv
// Load/store master turning byte-addressed byte/half/word requests into word-wide memory cycles,
// with read-modify-write for sub-word stores. Optional perf counters under LSU_PERF_CNT_EN.
module lsu_mem_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_WORD   = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [MEM_WORD-1:0]   req_wdata,
    output logic                  rsp_valid,
    output logic [MEM_WORD-1:0]   rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [MEM_WORD-1:0]   mem_w_data,
    output logic                  mem_w_ena,
    input  logic [MEM_WORD-1:0]   mem_r_data
`ifdef LSU_PERF_CNT_EN
    ,
    output logic [31:0]           ld_cnt,
    output logic [31:0]           st_cnt,
    output logic [15:0]           err_cnt
`endif
);

    // Handshake: a request is taken on a rising edge where req_valid && req_ready; the
    // requester holds req_* stable until then. rsp_valid is a one-cycle pulse, no backpressure.

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RMW_RD,
        S_WRITE,
        S_RESP
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            lane_q, lane_d;
    logic [1:0]            size_q, size_d;
    logic                  signed_q, signed_d;
    logic                  we_q, we_d;
    logic [15:0]           wdata_q, wdata_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [MEM_WORD-1:0]   mem_w_data_q, mem_w_data_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [MEM_WORD-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;

    logic                  misaligned;
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;
    logic [MEM_WORD-1:0]   load_data;
    logic [MEM_WORD-1:0]   merge_data;

    assign req_ready  = rst_n && (state_q == S_IDLE);
    assign mem_w_ena  = rst_n && (state_q == S_WRITE);
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign rsp_err    = rsp_err_q;
    assign mem_addr   = mem_addr_q;
    assign mem_w_data = mem_w_data_q;

    assign misaligned = (req_size == 2'b11) ||
                        ((req_size == 2'b01) && req_addr[0]) ||
                        ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));

    // Lane extraction for loads and lane merge for sub-word stores, both off the live read data.
    always_comb begin
        byte_sel   = mem_r_data[{lane_q, 3'b000} +: 8];
        half_sel   = lane_q[1] ? mem_r_data[31:16] : mem_r_data[15:0];
        load_data  = mem_r_data;
        merge_data = mem_r_data;
        case (size_q)
            2'b00: load_data = signed_q ? {{24{byte_sel[7]}}, byte_sel} : {24'h000000, byte_sel};
            2'b01: load_data = signed_q ? {{16{half_sel[15]}}, half_sel} : {16'h0000, half_sel};
            default: load_data = mem_r_data;
        endcase
        if (size_q == 2'b00) begin
            merge_data[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merge_data[{lane_q[1], 4'b0000} +: 16] = wdata_q;
        end
    end

    always_comb begin
        state_d      = state_q;
        lane_d       = lane_q;
        size_d       = size_q;
        signed_d     = signed_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        mem_addr_d   = mem_addr_q;
        mem_w_data_d = mem_w_data_q;
        rsp_valid_d  = 1'b0;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_err_d    = rsp_err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    lane_d     = req_addr[1:0];
                    size_d     = req_size;
                    signed_d   = req_signed;
                    we_d       = req_we;
                    wdata_d    = req_wdata[15:0];
                    mem_addr_d = {2'b00, req_addr[ADDR_WIDTH-1:2]};
                    if (misaligned) begin
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else if (!req_we) begin
                        state_d = S_LOAD;
                    end else if (req_size == 2'b10) begin
                        mem_w_data_d = req_wdata;
                        state_d      = S_WRITE;
                    end else begin
                        state_d = S_RMW_RD;
                    end
                end
            end
            S_LOAD: begin
                rsp_rdata_d = load_data;
                rsp_err_d   = 1'b0;
                rsp_valid_d = 1'b1;
                state_d     = S_RESP;
            end
            S_RMW_RD: begin
                mem_w_data_d = merge_data;
                state_d      = S_WRITE;
            end
            S_WRITE: begin
                rsp_rdata_d = '0;
                rsp_err_d   = 1'b0;
                rsp_valid_d = 1'b1;
                state_d     = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            lane_q       <= 2'b00;
            size_q       <= 2'b00;
            signed_q     <= 1'b0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            mem_addr_q   <= '0;
            mem_w_data_q <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            lane_q       <= lane_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            mem_addr_q   <= mem_addr_d;
            mem_w_data_q <= mem_w_data_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

`ifdef LSU_PERF_CNT_EN
    logic [31:0] ld_cnt_q;
    logic [31:0] st_cnt_q;
    logic [15:0] err_cnt_q;

    // Counted as the RESP cycle retires, so each response bumps exactly one counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ld_cnt_q  <= '0;
            st_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else if (state_q == S_RESP) begin
            if (rsp_err_q) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end else if (we_q) begin
                st_cnt_q <= st_cnt_q + 32'd1;
            end else begin
                ld_cnt_q <= ld_cnt_q + 32'd1;
            end
        end
    end

    assign ld_cnt  = ld_cnt_q;
    assign st_cnt  = st_cnt_q;
    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed testbench for lsu_mem_master with a behavioural word memory (async read, clocked write).
module tb_lsu_mem_master;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_w_data;
    logic        mem_w_ena;
    logic [31:0] mem_r_data;
`ifdef LSU_PERF_CNT_EN
    logic [31:0] ld_cnt;
    logic [31:0] st_cnt;
    logic [15:0] err_cnt;
`endif

    lsu_mem_master #(.ADDR_WIDTH(32), .MEM_WORD(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_addr   (mem_addr),
        .mem_w_data (mem_w_data),
        .mem_w_ena  (mem_w_ena),
        .mem_r_data (mem_r_data)
`ifdef LSU_PERF_CNT_EN
        ,
        .ld_cnt     (ld_cnt),
        .st_cnt     (st_cnt),
        .err_cnt    (err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [0:63];
    int          wr_cnt = 0;
    int          rsp_cnt = 0;
    logic [31:0] last_wa = '0;
    logic [31:0] last_wd = '0;

    assign mem_r_data = (mem_addr < 32'd64) ? mem[mem_addr[5:0]] : 32'h0;

    always @(posedge clk) begin
        if (mem_w_ena) begin
            wr_cnt  <= wr_cnt + 1;
            last_wa <= mem_addr;
            last_wd <= mem_w_data;
            if (mem_addr < 32'd64) mem[mem_addr[5:0]] <= mem_w_data;
        end
        if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    int          lat;
    logic [31:0] rd;
    logic        err;
    int          writes;

    // Issue one request from IDLE and wait (bounded) for its response pulse.
    task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wd);
        int w0;
        w0         = wr_cnt;
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wd;
        req_valid  = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        lat++;
        rd  = rsp_rdata;
        err = rsp_err;
        @(posedge clk); #1;
        chk("rsp_one_cycle", {31'd0, rsp_valid}, 32'd0);
        writes = wr_cnt - w0;
    endtask

    int w_base;
    int r_base;

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_size   = 2'b10;
        req_signed = 1'b0;
        req_addr   = 32'h40;
        req_wdata  = 32'h1111_2222;

        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
            chk("rst_mem_w_ena", {31'd0, mem_w_ena}, 32'd0);
            chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        end
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_mem_w_data", mem_w_data, 32'd0);
        req_valid = 1'b0;
        rst_n     = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
        chk("post_rst_writes", wr_cnt, 32'd0);

        // Word store to byte 0x10 -> word 4.
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
        chk("sw_lat", lat, 32'd2);
        chk("sw_err", {31'd0, err}, 32'd0);
        chk("sw_rdata", rd, 32'd0);
        chk("sw_writes", writes, 32'd1);
        chk("sw_addr", last_wa, 32'd4);
        chk("sw_data", last_wd, 32'hDEAD_BEEF);

        do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
        chk("lb_s_13", rd, 32'hFFFF_FFDE);
        chk("lb_s_lat", lat, 32'd2);
        chk("lb_s_writes", writes, 32'd0);
        do_req(1'b0, 2'b01, 1'b0, 32'h10, 32'h0);
        chk("lhu_10", rd, 32'h0000_BEEF);
        chk("lhu_lat", lat, 32'd2);
        do_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
        chk("lbu_13", rd, 32'h0000_00DE);
        do_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
        chk("lh_s_12", rd, 32'hFFFF_DEAD);
        do_req(1'b0, 2'b00, 1'b1, 32'h10, 32'h0);
        chk("lb_s_10", rd, 32'hFFFF_FFEF);
        do_req(1'b0, 2'b10, 1'b1, 32'h10, 32'h0);
        chk("lw_10", rd, 32'hDEAD_BEEF);

        // Sub-word stores go through read-modify-write.
        do_req(1'b1, 2'b00, 1'b0, 32'h11, 32'hFFFF_FF55);
        chk("sb_lat", lat, 32'd3);
        chk("sb_writes", writes, 32'd1);
        chk("sb_addr", last_wa, 32'd4);
        chk("sb_data", last_wd, 32'hDEAD_55EF);
        chk("sb_rdata", rd, 32'd0);
        do_req(1'b1, 2'b01, 1'b0, 32'h12, 32'hABCD_1234);
        chk("sh_lat", lat, 32'd3);
        chk("sh_data", last_wd, 32'h1234_55EF);
        chk("sh_mem", mem[4], 32'h1234_55EF);

        // Misaligned and reserved-size requests.
        do_req(1'b0, 2'b01, 1'b0, 32'h11, 32'h0);
        chk("lh_mis_lat", lat, 32'd1);
        chk("lh_mis_err", {31'd0, err}, 32'd1);
        chk("lh_mis_rdata", rd, 32'd0);
        do_req(1'b1, 2'b10, 1'b0, 32'h12, 32'hCAFE_F00D);
        chk("sw_mis_lat", lat, 32'd1);
        chk("sw_mis_err", {31'd0, err}, 32'd1);
        chk("sw_mis_writes", writes, 32'd0);
        do_req(1'b1, 2'b11, 1'b0, 32'h10, 32'hCAFE_F00D);
        chk("rsv_err", {31'd0, err}, 32'd1);
        chk("rsv_writes", writes, 32'd0);
        chk("mis_mem_kept", mem[4], 32'h1234_55EF);

        // Reset during the RMW read cycle must abort without any write or response.
        do_req(1'b1, 2'b10, 1'b0, 32'h14, 32'hA5A5_A5A5);
        chk("pre_rmw_mem", mem[5], 32'hA5A5_A5A5);
        w_base     = wr_cnt;
        r_base     = rsp_cnt;
        req_we     = 1'b1;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = 32'h14;
        req_wdata  = 32'h0000_0077;
        req_valid  = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst_n     = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
        end
        chk("abort_writes", wr_cnt - w_base, 32'd0);
        chk("abort_rsps", rsp_cnt - r_base, 32'd0);
        chk("abort_mem", mem[5], 32'hA5A5_A5A5);
        chk("abort_ready", {31'd0, req_ready}, 32'd1);
`ifdef LSU_PERF_CNT_EN
        chk("cnt_ld_zero", ld_cnt, 32'd0);
        chk("cnt_st_zero", st_cnt, 32'd0);
        chk("cnt_err_zero", {16'd0, err_cnt}, 32'd0);
`endif

        do_req(1'b0, 2'b10, 1'b0, 32'h14, 32'h0);
        chk("lw_after_abort", rd, 32'hA5A5_A5A5);
        do_req(1'b1, 2'b10, 1'b0, 32'h18, 32'h0BAD_CAFE);
        chk("sw_18_addr", last_wa, 32'd6);
        do_req(1'b0, 2'b11, 1'b0, 32'h18, 32'h0);
        chk("rsv_ld_err", {31'd0, err}, 32'd1);
`ifdef LSU_PERF_CNT_EN
        chk("cnt_ld_one", ld_cnt, 32'd1);
        chk("cnt_st_one", st_cnt, 32'd1);
        chk("cnt_err_one", {16'd0, err_cnt}, 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Load/store master on the initiator side of the word-wide data memory; the memory is the responder.
- Accepts byte/halfword/word load and store requests from the execute stage using byte addresses.
- Converts each request to word-indexed memory cycles. Memory interface: asynchronous read, write on rising clk edge when write-enable is high.
- Sub-word stores use read-modify-write, because the memory only supports whole-word writes.

Parameters:
- ADDR_WIDTH, 32, width of the byte address and of mem_addr.
- MEM_WORD, 32, data word width; fixed at 32 for lane logic.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  request present; requester holds all req_* stable until accepted
- req_ready  out  1  block idle, can accept a request
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as misaligned)
- req_signed  in  1  sign-extend sub-word loads
- req_addr  in  ADDR_WIDTH  byte address, little-endian
- req_wdata  in  MEM_WORD  store data, right-justified
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  MEM_WORD  load result (0 for stores and errors)
- rsp_err  out  1  misaligned or reserved-size request; no memory access made
- mem_addr  out  ADDR_WIDTH  word index = {2'b00, req_addr[ADDR_WIDTH-1:2]}
- mem_w_data  out  MEM_WORD  write data
- mem_w_ena  out  1  memory write enable
- mem_r_data  in  MEM_WORD  asynchronous read data for mem_addr

Behaviour:
- Reset values while rst_n low at a rising edge:
  - Registered outputs: state IDLE; rsp_valid 0, rsp_rdata 0, rsp_err 0, mem_addr 0, mem_w_data 0.
  - mem_w_ena and req_ready are gated combinationally to 0 while rst_n is low.
- Accept occurs when req_valid && req_ready at an edge (E0). Address, size, signed, we and data are registered. req_ready = (state==IDLE) && rst_n.
- States and transitions: IDLE, LOAD, RMW_RD, WRITE, RESP.
  - Misaligned at accept (half with addr[0]=1; word with addr[1:0]!=0; size 11) -> RESP, rsp_err=1. mem_w_ena never asserted.
  - Load -> LOAD: mem_addr driven; mem_r_data lane-extracted and captured at end of cycle -> RESP. rsp_valid in cycle 2 after E0.
  - Word store -> WRITE: mem_w_ena=1, mem_w_data=req_wdata for exactly one cycle -> RESP.
  - Byte/half store -> RMW_RD: capture mem_r_data and merge the new lane(s) -> WRITE with the merged word -> RESP. rsp_valid in cycle 3 after E0.
  - RESP: rsp_valid=1 for one cycle -> IDLE.
- Lane rules:
  - Byte lane = addr[1:0], bits [8*lane+7 : 8*lane].
  - Half lane = addr[1], bits [16*addr[1]+15 : 16*addr[1]].
  - Loads zero-extend when req_signed=0; otherwise replicate the lane MSB.
  - Merge preserves all untouched bytes exactly.
- rsp_rdata holds its value until the next RESP. It is 0 for stores and errors.
- req_valid while req_ready=0 is ignored; no queuing.
- Reset mid-operation: an outstanding access is aborted, no response is given, and no further mem_w_ena pulse occurs. A partial RMW never writes memory.
- Address wrap: mem_addr is a pure shift; the top 2 bits are 0, with no wrap handling.

Optional Feature:
- Macro LSU_PERF_CNT_EN. When defined, adds:
  - Output ld_cnt[31:0]: increments on each load RESP without error.
  - Output st_cnt[31:0]: increments on each store RESP without error.
  - Output err_cnt[15:0]: increments on each error RESP.
  - All cleared by reset. Wrap modulo 2^width.
- When undefined, the ports and logic are absent and the remaining behaviour is identical.

Test Plan:
- Reset held 3 cycles with req_valid=1 -> req_ready=0, mem_w_ena=0, rsp_valid=0. After release, req_ready=1 next cycle.
- Word store addr 0x10, data 0xDEADBEEF -> one cycle with mem_addr=4, mem_w_ena=1, mem_w_data=0xDEADBEEF; rsp_valid 2 cycles after accept, rsp_err=0.
- Memory word 4 = 0xDEADBEEF; signed byte load addr 0x13 -> rsp_rdata=0xFFFFFFDE. Unsigned half load addr 0x10 -> 0x0000BEEF. Each rsp_valid 2 cycles after accept.
- Memory word 4 = 0xDEADBEEF; byte store addr 0x11, data 0x55 -> RMW_RD then a single write of 0xDEAD55EF; rsp_valid 3 cycles after accept.
- Half load addr 0x11; word store addr 0x12 -> each gives rsp_valid 1 cycle after accept with rsp_err=1 and no mem_w_ena pulse.
- Reset asserted in the RMW_RD cycle of a byte store -> no mem_w_ena, no rsp_valid, memory word unchanged. With LSU_PERF_CNT_EN: counters read 0, then 1/1/1 after one load, one store and one error.
